// File: rtl/lut_sweep_pkg.sv
// Shared definitions for the LUT sweep evaluator: FSM encodings and the
// supported range of the input count N.
package lut_sweep_pkg;
  localparam int N_MIN = 1;
  localparam int N_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/lut_core.sv
// Purely combinational W:1 selector: returns truth-table bit 'sel'.
module lut_core #(
  parameter int N = 3
) (
  input  logic [(1<<N)-1:0] tt,
  input  logic [N-1:0]      sel,
  output logic              f
);
  assign f = tt[sel];
endmodule

// File: rtl/lut_sweep_eval.sv
// N-input Boolean function evaluator backed by a loadable 2**N-bit truth
// table. It supports single-vector registered evaluation and an exhaustive
// sweep that produces a ones count and a result signature.
// Optional table parity checking is enabled by defining LUT_PARITY_EN.
module lut_sweep_eval
  import lut_sweep_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tt_load,
  input  logic [(1<<N)-1:0]    tt_in,
  input  logic                 in_valid,
  input  logic [N-1:0]         in_vec,
  output logic                 out_valid,
  output logic                 out_f,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [N:0]           ones_cnt,
`ifdef LUT_PARITY_EN
  input  logic                 tt_par_in,
  output logic                 tt_err,
`endif
  output logic [(1<<N)-1:0]    sig
);
  localparam int W = 1 << N;

  state_t         state;
  logic [W-1:0]   tt;
  logic [N-1:0]   idx;
  logic [N-1:0]   sel;
  logic           f;
  logic           eval_go;

  // One selector is shared: the sweep owns it while busy, otherwise in_vec.
  assign sel     = busy ? idx : in_vec;
  assign eval_go = in_valid && !busy;

  lut_core #(.N(N)) u_core (
    .tt  (tt),
    .sel (sel),
    .f   (f)
  );

  // Truth-table register; frozen while a sweep is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tt <= '0;
    else if (tt_load && !busy) tt <= tt_in;
  end

  // Single-vector evaluation, one cycle latency, reads the pre-load table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_f     <= 1'b0;
    end else begin
      out_valid <= eval_go;
      if (eval_go) out_f <= f;
    end
  end

  // Sweep FSM: walks idx 0..W-1, shifting results in from the MSB side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      idx      <= '0;
      ones_cnt <= '0;
      sig      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= ST_SWEEP;
            busy     <= 1'b1;
            idx      <= '0;
            ones_cnt <= '0;
            sig      <= '0;
          end
        end
        ST_SWEEP: begin
          sig      <= {f, sig[W-1:1]};
          ones_cnt <= ones_cnt + (N+1)'(f);
          idx      <= idx + 1'b1;
          if (idx == N'(W-1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LUT_PARITY_EN
  logic tt_par;

  // Parity bit stored alongside the table under the same load condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tt_par <= 1'b0;
    else if (tt_load && !busy) tt_par <= tt_par_in;
  end

  // Sticky parity error: re-checked on each use, cleared by a matching load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tt_err <= 1'b0;
    else if (tt_load && !busy && ((^tt_in) == tt_par_in)) tt_err <= 1'b0;
    else if (eval_go || state == ST_SWEEP) tt_err <= tt_err | ((^tt) != tt_par);
  end
`endif
endmodule

// File: tb/tb_lut_sweep_eval.sv
// Scoreboard bench for lut_sweep_eval (N=3): stimulus pushes expected eval
// and sweep results into queues; a negedge monitor pops and compares.
module tb_lut_sweep_eval;
  localparam int N = 3;
  localparam int W = 1 << N;

  logic          clk = 1'b0;
  logic          rst;
  logic          tt_load;
  logic [W-1:0]  tt_in;
  logic          in_valid;
  logic [N-1:0]  in_vec;
  logic          out_valid;
  logic          out_f;
  logic          start;
  logic          busy;
  logic          done;
  logic [N:0]    ones_cnt;
  logic [W-1:0]  sig;
`ifdef LUT_PARITY_EN
  logic          tt_par_in;
  logic          tt_err;
`endif

  typedef struct {
    logic [N:0]   ones;
    logic [W-1:0] sg;
  } sweep_exp_t;

  logic       eval_q[$];
  sweep_exp_t sweep_q[$];
  int         checks = 0;
  int         failures = 0;

  lut_sweep_eval #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .tt_load   (tt_load),
    .tt_in     (tt_in),
    .in_valid  (in_valid),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_f     (out_f),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ones_cnt  (ones_cnt),
`ifdef LUT_PARITY_EN
    .tt_par_in (tt_par_in),
    .tt_err    (tt_err),
`endif
    .sig       (sig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented result must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (eval_q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        else chk("out_f", 32'(out_f), 32'(eval_q.pop_front()));
      end
      if (done) begin
        if (sweep_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
        else begin
          sweep_exp_t e;
          e = sweep_q.pop_front();
          chk("ones_cnt", 32'(ones_cnt), 32'(e.ones));
          chk("sig", 32'(sig), 32'(e.sg));
        end
      end
    end
  end

  task automatic idle_inputs();
    tt_load = 1'b0; in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic load_tt(input logic [W-1:0] v);
    @(negedge clk);
    tt_load = 1'b1; tt_in = v;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic eval_one(input logic [N-1:0] v, input logic exp);
    @(negedge clk);
    in_valid = 1'b1; in_vec = v;
    eval_q.push_back(exp);
    @(negedge clk);
    idle_inputs();
  endtask

  // Start a sweep, count busy cycles, optionally poke ignored inputs mid-sweep.
  task automatic run_sweep(input logic [N:0] ones, input logic [W-1:0] sg, input int poke);
    int  cnt = 0;
    bit  seen = 0;
    sweep_exp_t e;
    e.ones = ones; e.sg = sg;
    sweep_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      idle_inputs();
      if (done) begin seen = 1; break; end
      if (busy) cnt++;
      if (poke != 0 && cnt == poke) begin
        start = 1'b1; tt_load = 1'b1; tt_in = '0; in_valid = 1'b1; in_vec = '0;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_cycles", 32'(cnt), 32'(W));
  endtask

  initial begin
    rst = 1'b1; tt_in = '0; in_vec = '0;
`ifdef LUT_PARITY_EN
    tt_par_in = 1'b0;
`endif
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ones", 32'(ones_cnt), 32'd0);
    chk("rst_sig", 32'(sig), 32'd0);
    rst = 1'b0;

    // Majority-like table E8: 4 ones.
    load_tt(8'hE8);
    run_sweep(4'd4, 8'hE8, 0);

    // Back-to-back evaluations.
    @(negedge clk);
    in_valid = 1'b1; in_vec = 3'b011; eval_q.push_back(1'b1);
    @(negedge clk);
    in_vec = 3'b100; eval_q.push_back(1'b0);
    @(negedge clk);
    idle_inputs();

    // Same-cycle load and eval uses the old table.
    load_tt(8'h00);
    @(negedge clk);
    tt_load = 1'b1; tt_in = 8'hFF; in_valid = 1'b1; in_vec = 3'd0;
    eval_q.push_back(1'b0);
    @(negedge clk);
    idle_inputs();
    eval_one(3'd0, 1'b1);
    run_sweep(4'd8, 8'hFF, 0);

    // Mid-sweep start/load/eval are all ignored.
    load_tt(8'h96);
    run_sweep(4'd4, 8'h96, 3);
    eval_one(3'd1, 1'b1);
    eval_one(3'd0, 1'b0);

    // Reset in the middle of a sweep aborts without a done pulse.
    @(negedge clk);
    start = 1'b1;
    repeat (4) @(negedge clk) idle_inputs();
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ones", 32'(ones_cnt), 32'd0);
    chk("abort_sig", 32'(sig), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    eval_one(3'd7, 1'b0);
    load_tt(8'hE8);
    run_sweep(4'd4, 8'hE8, 0);

`ifdef LUT_PARITY_EN
    @(negedge clk);
    tt_load = 1'b1; tt_in = 8'h01; tt_par_in = 1'b0;
    @(negedge clk);
    idle_inputs();
    eval_one(3'd0, 1'b1);
    chk("tt_err_set", 32'(tt_err), 32'd1);
    @(negedge clk);
    tt_load = 1'b1; tt_in = 8'h01; tt_par_in = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk("tt_err_clear", 32'(tt_err), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("eval_q_empty", 32'(eval_q.size()), 32'd0);
    chk("sweep_q_empty", 32'(sweep_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
